poly_sweep_ctrl: RTL and testbench
==================================

// Module: poly_sweep_ctrl
// PURPOSE
//  Upstream sequencer for the polynomial function block (Top). It generates an
//  arithmetic sweep of Q24.8 x values and drives Top's start_func/func_done
//  handshake one point at a time. Each result (Q56.8 y plus overflow) is
//  captured and presented downstream on a valid/ready result port. The block
//  replaces hand-driven x stepping with a reusable, timeout-guarded controller.
// PARAMETERS
//  CNT_W        16    width of point count and index
//  TIMEOUT_CYC  1024  max cycles spent in WAIT_DONE or RELEASE before abort (>=2)
// PORTS
//  clk          in   1      clock; all logic on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  sweep_start  in   1      pulse; starts a sweep when IDLE, ignored otherwise
//  x_base       in   32     signed Q24.8 first x, sampled with sweep_start
//  x_step       in   32     signed Q24.8 increment, sampled with sweep_start
//  n_points     in   CNT_W  number of points, sampled with sweep_start
//  busy         out  1      high in every state except IDLE
//  sweep_done   out  1      one-cycle pulse at sweep end (normal or abort)
//  timeout_err  out  1      sticky abort flag; cleared by accepted sweep_start
//  start_func   out  1      to Top: request evaluation of func_x
//  func_x       out  32     to Top x_in: signed Q24.8, stable while start_func=1
//  func_done    in   1      from Top: result valid
//  func_y       in   64     from Top y_out: Q56.8
//  func_ovf     in   1      from Top overflow
//  res_valid    out  1      result available
//  res_ready    in   1      downstream accepts result
//  res_x        out  32     x of this result
//  res_y        out  64     captured func_y
//  res_ovf      out  1      captured func_ovf
//  res_idx      out  CNT_W  point index, 0-based
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; all outputs 0, including
//   start_func, res_valid and timeout_err. This also applies mid-sweep, with
//   no drain.
//  States: IDLE, ISSUE, WAIT_DONE, RELEASE, EMIT. All outputs are registered.
//  IDLE: if sweep_start=1 and n_points=0, pulse sweep_done next cycle and stay
//   IDLE. If sweep_start=1 and n_points>0, latch inputs, idx=0, x=x_base,
//   clear timeout_err, go to ISSUE.
//  ISSUE (1 cycle): set start_func=1 and func_x=x; go to WAIT_DONE and clear
//   the timeout counter.
//  WAIT_DONE: hold start_func=1 and func_x. On func_done=1 sampled, capture
//   func_y->res_y, func_ovf->res_ovf, x->res_x, idx->res_idx; drive
//   start_func=0 from the next cycle; go to RELEASE.
//  RELEASE: wait for func_done=0 (Top returns to idle), then go to EMIT with
//   res_valid=1.
//  EMIT: hold res_* stable while res_valid & !res_ready. On res_valid &
//   res_ready, drop res_valid. If idx==n_points-1, pulse sweep_done and go to
//   IDLE. Otherwise x<=x+x_step, idx<=idx+1, go to ISSUE.
//  Minimum per-point overhead beyond Top latency: ISSUE 1 + RELEASE >=1 +
//   EMIT >=1 cycles.
//  Timeout: the counter increments in WAIT_DONE and RELEASE. When it reaches
//   TIMEOUT_CYC: start_func=0, timeout_err=1, pulse sweep_done, go to IDLE.
//   No result is emitted for the aborted point, and the remaining points are
//   dropped.
//  x arithmetic: 32-bit two's complement, wraps modulo 2^32 with no flag.
//   Fractional bits are kept as-is; no rounding.
//  func_done=1 while in IDLE, ISSUE or EMIT is ignored.
//  sweep_start while busy is ignored; latched parameters do not change
//   mid-sweep.
// TESTING
//  1 Behavioural Top model (y=x^2, latency 3). Stimulus: base=0x100,
//    step=0x100, n=10, res_ready=1. Required: 10 results with res_x=0x100..0xA00,
//    res_idx 0..9, res_y=x*x>>8, exactly one sweep_done, timeout_err=0.
//  2 Backpressure: hold res_ready=0 for 5 cycles on idx=3. Required: res_*
//    stable, res_valid held, start_func stays 0, no idx=4 issued until accept.
//  3 n_points=0. Required: sweep_done high for exactly 1 cycle, one cycle
//    after sweep_start; start_func and res_valid never assert.
//  4 Stub never raises func_done, TIMEOUT_CYC=16. Required: start_func drops
//    after 16 WAIT cycles, timeout_err=1, one sweep_done pulse, no res_valid.
//    The next sweep_start clears timeout_err.
//  5 Assert rst_n=0 during WAIT_DONE of point 2. Required: all outputs 0 at the
//    next edge; a fresh sweep then completes normally from idx 0.
//  6 base=0x7FFFFF00, step=0x100, n=2, stub func_ovf=1 on idx 1 only.
//    Required: res_x=0x7FFFFF00 then 0x80000000; res_ovf=0 then 1.

Source files
------------

// File: rtl/poly_sweep_ctrl.sv
// Sweep sequencer for the polynomial block: steps x arithmetically, runs the
// start_func/func_done handshake per point and emits each result on valid/ready.
module poly_sweep_ctrl #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sweep_start,
    input  logic [31:0]       x_base,
    input  logic [31:0]       x_step,
    input  logic [CNT_W-1:0]  n_points,
    output logic              busy,
    output logic              sweep_done,
    output logic              timeout_err,
    output logic              start_func,
    output logic [31:0]       func_x,
    input  logic              func_done,
    input  logic [63:0]       func_y,
    input  logic              func_ovf,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_x,
    output logic [63:0]       res_y,
    output logic              res_ovf,
    output logic [CNT_W-1:0]  res_idx
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RELEASE,
        EMIT
    } state_t;

    state_t           state, state_n;
    logic [31:0]      x_cur, step_q;
    logic [CNT_W-1:0] idx, n_q;
    logic [TO_W-1:0]  tcnt;

    logic do_empty, do_load, do_issue, do_capture, do_release;
    logic do_accept, do_last, do_abort, do_tick, timed_out;

    assign timed_out = (tcnt == TO_LAST);

    always_comb begin
        state_n    = state;
        do_empty   = 1'b0;
        do_load    = 1'b0;
        do_issue   = 1'b0;
        do_capture = 1'b0;
        do_release = 1'b0;
        do_accept  = 1'b0;
        do_last    = 1'b0;
        do_abort   = 1'b0;
        do_tick    = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    if (n_points == '0) begin
                        do_empty = 1'b1;
                    end else begin
                        do_load = 1'b1;
                        state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                do_issue = 1'b1;
                state_n  = WAIT_DONE;
            end
            // Progress wins over the timeout when both land on the same edge.
            WAIT_DONE: begin
                if (func_done) begin
                    do_capture = 1'b1;
                    state_n    = RELEASE;
                end else if (timed_out) begin
                    do_abort = 1'b1;
                    state_n  = IDLE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            RELEASE: begin
                if (!func_done) begin
                    do_release = 1'b1;
                    state_n    = EMIT;
                end else if (timed_out) begin
                    do_abort = 1'b1;
                    state_n  = IDLE;
                end else begin
                    do_tick = 1'b1;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    do_accept = 1'b1;
                    if (idx == n_q - CNT_W'(1)) begin
                        do_last = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
            start_func  <= 1'b0;
            func_x      <= '0;
            res_valid   <= 1'b0;
            res_x       <= '0;
            res_y       <= '0;
            res_ovf     <= 1'b0;
            res_idx     <= '0;
            x_cur       <= '0;
            step_q      <= '0;
            idx         <= '0;
            n_q         <= '0;
            tcnt        <= '0;
        end else begin
            state      <= state_n;
            busy       <= (state_n != IDLE);
            sweep_done <= do_empty | do_abort | do_last;
            if (do_empty | do_load) timeout_err <= 1'b0;
            if (do_abort)           timeout_err <= 1'b1;
            if (do_load) begin
                x_cur  <= x_base;
                step_q <= x_step;
                n_q    <= n_points;
                idx    <= '0;
            end
            if (do_issue) begin
                start_func <= 1'b1;
                func_x     <= x_cur;
                tcnt       <= '0;
            end
            if (do_tick) tcnt <= tcnt + TO_W'(1);
            if (do_capture) begin
                start_func <= 1'b0;
                res_y      <= func_y;
                res_ovf    <= func_ovf;
                res_x      <= x_cur;
                res_idx    <= idx;
            end
            if (do_abort)   start_func <= 1'b0;
            if (do_release) res_valid  <= 1'b1;
            if (do_accept) begin
                res_valid <= 1'b0;
                if (!do_last) begin
                    x_cur <= x_cur + step_q;
                    idx   <= idx + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_sweep_ctrl.sv
// Bench for poly_sweep_ctrl: behavioural Top stub (y = x^2, latency 3) plus a
// reference model that derives every expected point from the sweep parameters.
module tb_poly_sweep_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned TO    = 16;
    localparam int          LAT   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sweep_start;
    logic [31:0]       x_base, x_step;
    logic [CNT_W-1:0]  n_points;
    logic              busy, sweep_done, timeout_err, start_func;
    logic [31:0]       func_x;
    logic              func_done;
    logic [63:0]       func_y;
    logic              func_ovf;
    logic              res_valid, res_ready;
    logic [31:0]       res_x;
    logic [63:0]       res_y;
    logic              res_ovf;
    logic [CNT_W-1:0]  res_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    poly_sweep_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start),
        .x_base(x_base), .x_step(x_step), .n_points(n_points),
        .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err),
        .start_func(start_func), .func_x(func_x), .func_done(func_done),
        .func_y(func_y), .func_ovf(func_ovf), .res_valid(res_valid),
        .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
        .res_ovf(res_ovf), .res_idx(res_idx)
    );

    // Reference arithmetic: x_i = base + i*step mod 2^32, y = x^2 >> 8,
    // and the stub flags overflow for negative x.
    function automatic logic [31:0] ref_x(input logic [31:0] base, input logic [31:0] step, input int i);
        return base + step * 32'(i);
    endfunction

    function automatic logic [63:0] ref_y(input logic [31:0] x);
        logic signed [63:0] s;
        s = {{32{x[31]}}, x};
        return 64'((s * s) >>> 8);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x);
        return x[31];
    endfunction

    // Behavioural Top: done rises LAT cycles after start_func, falls once start_func drops.
    logic top_dead;
    int   lat;
    always @(posedge clk) begin
        if (!rst_n) begin
            func_done <= 1'b0;
            func_y    <= '0;
            func_ovf  <= 1'b0;
            lat       <= 0;
        end else if (!start_func || top_dead) begin
            func_done <= 1'b0;
            lat       <= 0;
        end else if (!func_done) begin
            if (lat == LAT - 1) begin
                func_done <= 1'b1;
                func_y    <= ref_y(func_x);
                func_ovf  <= ref_ovf(func_x);
            end else begin
                lat <= lat + 1;
            end
        end
    end

    logic [31:0]      obs_x[$];
    logic [63:0]      obs_y[$];
    logic             obs_ovf[$];
    logic [CNT_W-1:0] obs_idx[$];
    int done_cnt, done_cyc, sf_cycles, rv_cycles, stall_cyc, stall_bad;
    logic te_first;
    bit   run_expired;

    // Drives one sweep and records what the DUT emitted; callers do the checking.
    task automatic run_sweep(input logic [31:0] base, input logic [31:0] step,
                             input logic [CNT_W-1:0] n, input int hold_idx, input bit rand_ready);
        logic [31:0] sx; logic [63:0] sy; logic so; logic [CNT_W-1:0] si;
        int post;
        obs_x.delete(); obs_y.delete(); obs_ovf.delete(); obs_idx.delete();
        done_cnt = 0; done_cyc = -1; sf_cycles = 0; rv_cycles = 0;
        stall_cyc = 0; stall_bad = 0; run_expired = 0; te_first = 1'bx;
        sx = '0; sy = '0; so = 1'b0; si = '0;
        post = -1;
        @(negedge clk);
        x_base = base; x_step = step; n_points = n; sweep_start = 1'b1; res_ready = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                sweep_start = 1'b0;
                te_first    = timeout_err;
            end
            res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_idx >= 0 && res_valid && int'(res_idx) == hold_idx && stall_cyc < 5) begin
                if (stall_cyc == 0) begin
                    sx = res_x; sy = res_y; so = res_ovf; si = res_idx;
                end
                if ({res_x, res_y, res_ovf, res_idx} !== {sx, sy, so, si} || start_func !== 1'b0)
                    stall_bad++;
                stall_cyc++;
                res_ready = 1'b0;
            end
            if (start_func) sf_cycles++;
            if (res_valid)  rv_cycles++;
            if (sweep_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (res_valid && res_ready) begin
                obs_x.push_back(res_x); obs_y.push_back(res_y);
                obs_ovf.push_back(res_ovf); obs_idx.push_back(res_idx);
            end
            if (post < 0 && sweep_done) post = 3;
            else if (post > 0) post--;
            if (post == 0) break;
        end
        if (post != 0) run_expired = 1;
        res_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, sweep_done, timeout_err, start_func, func_x, res_valid, res_x, res_y, res_ovf, res_idx} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b terr=%b sf=%b fx=%h rv=%b rx=%h ry=%h ro=%b ri=%0d, want all 0",
                     busy, sweep_done, timeout_err, start_func, func_x, res_valid, res_x, res_y, res_ovf, res_idx);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] rx;
        run_sweep(32'h100, 32'h100, 10, -1, 0);
        checks++;
        if (run_expired || done_cnt != 1) begin
            errors++; $display("FAIL basic_done: got pulses=%0d expired=%0b, want 1 pulse", done_cnt, run_expired);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++; $display("FAIL basic_terr: got %b, want 0", timeout_err);
        end
        checks++;
        if (obs_x.size() != 10) begin
            errors++; $display("FAIL basic_count: got %0d results, want 10", obs_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < 10; i++) begin
            rx = ref_x(32'h100, 32'h100, i);
            checks++;
            if ({obs_x[i], obs_y[i], obs_ovf[i], obs_idx[i]} !== {rx, ref_y(rx), ref_ovf(rx), 16'(i)}) begin
                errors++;
                $display("FAIL basic_point %0d: got x=%h y=%h ovf=%b idx=%0d, want x=%h y=%h ovf=%b idx=%0d",
                         i, obs_x[i], obs_y[i], obs_ovf[i], obs_idx[i], rx, ref_y(rx), ref_ovf(rx), i);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] base, step, rx;
        int n;
        for (int s = 0; s < 4; s++) begin
            base = $urandom; step = $urandom; n = $urandom_range(1, 8);
            run_sweep(base, step, CNT_W'(n), -1, 1);
            checks++;
            if (run_expired || done_cnt != 1 || obs_x.size() != n) begin
                errors++;
                $display("FAIL random_sweep %0d: got pulses=%0d results=%0d expired=%0b, want 1 pulse %0d results",
                         s, done_cnt, obs_x.size(), run_expired, n);
            end
            for (int i = 0; i < obs_x.size() && i < n; i++) begin
                rx = ref_x(base, step, i);
                checks++;
                if ({obs_x[i], obs_y[i], obs_ovf[i], obs_idx[i]} !== {rx, ref_y(rx), ref_ovf(rx), 16'(i)}) begin
                    errors++;
                    $display("FAIL random_point %0d.%0d: got x=%h y=%h ovf=%b idx=%0d, want x=%h y=%h ovf=%b idx=%0d",
                             s, i, obs_x[i], obs_y[i], obs_ovf[i], obs_idx[i], rx, ref_y(rx), ref_ovf(rx), i);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] base, step, rx;
        base = $urandom; step = $urandom;
        run_sweep(base, step, 6, 3, 0);
        checks++;
        if (stall_cyc != 5 || stall_bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: got stall=%0d bad=%0d, want stall=5 bad=0", stall_cyc, stall_bad);
        end
        checks++;
        if (run_expired || done_cnt != 1 || obs_x.size() != 6) begin
            errors++;
            $display("FAIL backpressure_count: got pulses=%0d results=%0d, want 1 and 6", done_cnt, obs_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < 6; i++) begin
            rx = ref_x(base, step, i);
            checks++;
            if ({obs_x[i], obs_y[i], obs_ovf[i], obs_idx[i]} !== {rx, ref_y(rx), ref_ovf(rx), 16'(i)}) begin
                errors++;
                $display("FAIL backpressure_point %0d: got x=%h y=%h idx=%0d, want x=%h y=%h idx=%0d",
                         i, obs_x[i], obs_y[i], obs_idx[i], rx, ref_y(rx), i);
            end
        end
    endtask

    task automatic test_empty;
        run_sweep($urandom, $urandom, 0, -1, 0);
        checks++;
        if (done_cnt != 1 || done_cyc != 1) begin
            errors++; $display("FAIL empty_done: got pulses=%0d at cycle %0d, want 1 at cycle 1", done_cnt, done_cyc);
        end
        checks++;
        if (sf_cycles != 0 || rv_cycles != 0) begin
            errors++; $display("FAIL empty_quiet: got start_func cycles=%0d res_valid cycles=%0d, want 0 and 0", sf_cycles, rv_cycles);
        end
    endtask

    task automatic test_timeout;
        top_dead = 1'b1;
        run_sweep($urandom, $urandom, 3, -1, 0);
        top_dead = 1'b0;
        checks++;
        if (sf_cycles != TO) begin
            errors++; $display("FAIL timeout_wait: got start_func cycles=%0d, want %0d", sf_cycles, TO);
        end
        checks++;
        if (run_expired || done_cnt != 1 || rv_cycles != 0) begin
            errors++; $display("FAIL timeout_abort: got pulses=%0d res_valid cycles=%0d, want 1 and 0", done_cnt, rv_cycles);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++; $display("FAIL timeout_flag: got %b, want 1", timeout_err);
        end
        run_sweep(32'h40, 32'h20, 2, -1, 0);
        checks++;
        if (te_first !== 1'b0 || timeout_err !== 1'b0 || obs_x.size() != 2) begin
            errors++;
            $display("FAIL timeout_clear: got terr_after_start=%b terr_end=%b results=%0d, want 0 0 2",
                     te_first, timeout_err, obs_x.size());
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] base, step, rx;
        int rises;
        logic prev;
        bit found;
        rises = 0; prev = 1'b0; found = 0;
        base = $urandom; step = $urandom;
        @(negedge clk);
        x_base = base; x_step = step; n_points = 5; sweep_start = 1'b1; res_ready = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            sweep_start = 1'b0;
            if (start_func && !prev) rises++;
            prev = start_func;
            if (rises == 3 && start_func) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL reset_mid_reach: got %0d issues, want point 2 in flight", rises);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sweep_done, timeout_err, start_func, func_x, res_valid, res_x, res_y, res_ovf, res_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b sf=%b fx=%h rv=%b rx=%h ri=%0d, want all 0",
                     busy, start_func, func_x, res_valid, res_x, res_idx);
        end
        rst_n = 1'b1;
        run_sweep(base, step, 4, -1, 0);
        checks++;
        if (run_expired || done_cnt != 1 || obs_x.size() != 4) begin
            errors++; $display("FAIL reset_mid_rerun: got pulses=%0d results=%0d, want 1 and 4", done_cnt, obs_x.size());
        end
        for (int i = 0; i < obs_x.size() && i < 4; i++) begin
            rx = ref_x(base, step, i);
            checks++;
            if ({obs_x[i], obs_y[i], obs_idx[i]} !== {rx, ref_y(rx), 16'(i)}) begin
                errors++;
                $display("FAIL reset_mid_point %0d: got x=%h idx=%0d, want x=%h idx=%0d", i, obs_x[i], obs_idx[i], rx, i);
            end
        end
    endtask

    task automatic test_wrap;
        run_sweep(32'h7FFF_FF00, 32'h100, 2, -1, 0);
        checks++;
        if (obs_x.size() != 2) begin
            errors++; $display("FAIL wrap_count: got %0d results, want 2", obs_x.size());
        end else begin
            checks++;
            if ({obs_x[0], obs_ovf[0], obs_x[1], obs_ovf[1]} !== {32'h7FFF_FF00, 1'b0, 32'h8000_0000, 1'b1}) begin
                errors++;
                $display("FAIL wrap_points: got x0=%h ovf0=%b x1=%h ovf1=%b, want 7fffff00 0 80000000 1",
                         obs_x[0], obs_ovf[0], obs_x[1], obs_ovf[1]);
            end
            checks++;
            if (obs_y[1] !== ref_y(32'h8000_0000)) begin
                errors++; $display("FAIL wrap_y: got %h, want %h", obs_y[1], ref_y(32'h8000_0000));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sweep_start = 1'b0; x_base = '0; x_step = '0;
        n_points = '0; res_ready = 1'b1; top_dead = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
